// File: rtl/overlapping_sequence_detector.sv
// Moore FSM that flags every occurrence of the serial pattern 0100110
// (first-received bit first), with overlapping matches allowed.
// State Sk means the most recent k bits equal the first k pattern bits;
// S7 is a complete match and is the only state that drives y_out high.
module overlapping_sequence_detector (
  output logic y_out,
  input  logic x_in,
  input  logic clock,
  input  logic reset
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  state_t state;
  state_t next_state;

  // State register; synchronous reset wins over any transition and discards partial matches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // Next state from the longest pattern prefix that is still a suffix of the received bits.
  always_comb begin
    next_state = S0;
    unique case (state)
      S0: next_state = x_in ? S0 : S1;
      S1: next_state = x_in ? S2 : S1;
      S2: next_state = x_in ? S0 : S3;
      S3: next_state = x_in ? S2 : S4;
      S4: next_state = x_in ? S5 : S1;
      S5: next_state = x_in ? S6 : S3;
      S6: next_state = x_in ? S0 : S7;
      S7: next_state = x_in ? S2 : S1;
      default: next_state = S0;
    endcase
  end

  // Output depends only on the registered state, so x_in never reaches y_out combinationally.
  always_comb begin
    y_out = (state == S7);
  end

endmodule

// File: tb/tb_overlapping_sequence_detector.sv
// Self-checking bench for overlapping_sequence_detector: directed pattern
// cases followed by a long random bit stream with occasional resets, all
// compared against a reference that looks at the last seven bits received.
module tb_overlapping_sequence_detector;

  logic clock;
  logic reset;
  logic x_in;
  logic y_out;

  int compare_count;
  int mismatch_count;

  // Reference model: bits received since the last reset, newest in bit 0.
  logic [6:0] history;
  int         bits_since_reset;
  int         pulse_count;
  int         first_pulse_pos;

  localparam logic [6:0] PATTERN = 7'b0100110;

  overlapping_sequence_detector dut (
    .y_out (y_out),
    .x_in  (x_in),
    .clock (clock),
    .reset (reset)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, update the reference, and compare y_out just after the edge.
  task automatic applyStimulus(input logic rst, input logic bit_in, input string tag);
    logic expected_y;
    @(negedge clock);
    reset = rst;
    x_in  = bit_in;
    @(posedge clock);
    #1;
    if (rst) begin
      history          = 7'd0;
      bits_since_reset = 0;
    end else begin
      history          = {history[5:0], bit_in};
      bits_since_reset = bits_since_reset + 1;
    end
    expected_y = (bits_since_reset >= 7) && (history == PATTERN);
    checkOutput(tag, y_out, expected_y);
    if (y_out === 1'b1) begin
      pulse_count++;
      if (first_pulse_pos < 0) first_pulse_pos = bits_since_reset;
    end
  endtask

  task automatic do_reset(input int edges);
    for (int i = 0; i < edges; i++) applyStimulus(1'b1, 1'b0, "reset");
    pulse_count     = 0;
    first_pulse_pos = -1;
  endtask

  // Reset, then feed len bits (first bit in position len-1) and check pulse count and position.
  task automatic run_seq(input logic [31:0] bits, input int len, input string tag,
                         input int exp_pulses, input int exp_first);
    do_reset(2);
    for (int i = 0; i < len; i++) applyStimulus(1'b0, bits[len-1-i], tag);
    applyStimulus(1'b0, 1'b1, tag);
    checkOutput({tag, "_pulses"}, pulse_count, exp_pulses);
    checkOutput({tag, "_first"}, first_pulse_pos, exp_first);
  endtask

  initial begin
    compare_count    = 0;
    mismatch_count   = 0;
    history          = 7'd0;
    bits_since_reset = 0;
    pulse_count      = 0;
    first_pulse_pos  = -1;
    reset            = 1'b1;
    x_in             = 1'b0;

    // Two reset edges then five ones: never a pulse.
    do_reset(2);
    checkOutput("reset_y", y_out, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, "ones_after_reset");
    checkOutput("ones_pulses", pulse_count, 0);

    run_seq(32'b0100110, 7, "single_match", 1, 7);
    run_seq(32'b0100110100110, 13, "overlap_match", 2, 7);
    run_seq(32'b00011000100110100000, 20, "embedded_match", 1, 14);
    run_seq(32'b0100100110, 10, "s5_fallback", 1, 10);

    // Partial match interrupted by reset must be forgotten.
    do_reset(2);
    applyStimulus(1'b0, 1'b0, "reset_mid");
    applyStimulus(1'b0, 1'b1, "reset_mid");
    applyStimulus(1'b0, 1'b0, "reset_mid");
    applyStimulus(1'b0, 1'b0, "reset_mid");
    applyStimulus(1'b0, 1'b1, "reset_mid");
    applyStimulus(1'b1, 1'b1, "reset_mid");
    applyStimulus(1'b0, 1'b1, "reset_mid");
    applyStimulus(1'b0, 1'b0, "reset_mid");
    applyStimulus(1'b0, 1'b0, "reset_mid");
    checkOutput("reset_mid_pulses", pulse_count, 0);

    // Reset asserted while a match is being reported clears y_out at that edge.
    run_seq(32'b0100110, 7, "match_before_reset", 1, 7);
    do_reset(2);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, PATTERN[6-i], "reset_in_s7");
    checkOutput("reached_s7", y_out, 1'b1);
    applyStimulus(1'b1, 1'b0, "reset_in_s7");
    checkOutput("s7_cleared", y_out, 1'b0);

    // Random stream, biased toward pattern prefixes, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic rb;
      logic xb;
      rb = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 3) == 0) xb = $urandom_range(0, 1);
      else xb = PATTERN[6 - (bits_since_reset % 6)];
      applyStimulus(rb, xb, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/overlapping_sequence_detector.md
OVERLAPPING_SEQUENCE_DETECTOR -- requirements
Module: overlapping_sequence_detector

Interface
- No parameters; the detected pattern is fixed at 0100110 (first-received bit first).
- REQ-001 The module SHALL have a port `clock`: input, 1 bit; the single clock, with all state updated on its rising edge.
- REQ-002 The module SHALL have a port `reset`: input, 1 bit; synchronous, active-high reset.
- REQ-003 The module SHALL have a port `x_in`: input, 1 bit; serial data bit, sampled on each rising edge of `clock`.
- REQ-004 The module SHALL have a port `y_out`: output, 1 bit; detection flag.
- REQ-005 Port order in the module header SHALL be (y_out, x_in, clock, reset).
- REQ-006 The design SHALL use one clock, with a synchronous, active-high reset.

Function
- REQ-007 The block SHALL be a Moore FSM detecting the serial pattern 0100110, with overlapping matches allowed.
- REQ-008 The FSM SHALL have eight states S0..S7, where Sk means the last k received bits equal the first k pattern bits; S7 means a full match. It SHALL use a 3-bit state register.
- REQ-009 Transitions SHALL be as follows, written as (x=0 / x=1):
  - S0: S1 / S0
  - S1: S1 / S2
  - S2: S3 / S0
  - S3: S4 / S2
  - S4: S1 / S5
  - S5: S3 / S6
  - S6: S7 / S0
  - S7: S1 / S2
- REQ-010 y_out SHALL be 1 only while in S7, and 0 in all other states.
- REQ-011 y_out SHALL be a pure function of the state register, with no combinational path from x_in.
- REQ-012 Latency: y_out SHALL rise in the cycle immediately after the rising edge that samples the 7th pattern bit. It SHALL stay high for exactly one cycle per match.
- REQ-013 Overlap: after a match, the trailing 0 SHALL count as pattern bit 1. Example: 0100110100110 yields two matches, 6 bits apart.
- REQ-014 Back-to-back matches SHALL produce separate one-cycle pulses, with no merging and no missed detections.
- REQ-015 Unreachable state encodings, if any exist, SHALL transition to S0 on the next edge.
- REQ-016 The FSM SHALL contain no other storage besides the state register.

Reset
- REQ-017 On a rising edge with reset=1, the state SHALL become S0 regardless of x_in, and y_out SHALL read 0 from that edge on.
- REQ-018 Reset SHALL take priority over all transitions.
- REQ-019 A partial match in progress SHALL be discarded by reset. Bits sampled on reset edges SHALL NOT count toward any pattern.
- REQ-020 Asserting reset while in S7 SHALL clear y_out at that edge.
- REQ-021 After reset is released, the first sampled bit SHALL be evaluated from S0.
- REQ-022 The FSM SHALL NOT respond to reset between clock edges.

Verification
- REQ-023 Bench: hold reset=1 for 2 edges, then x_in=1 for 5 edges. Required: y_out=0 throughout, and the FSM remains in S0.
- REQ-024 Bench: after reset, apply 0,1,0,0,1,1,0. Required: y_out=1 for exactly one cycle after the 7th edge, and 0 in all other cycles.
- REQ-025 Bench: apply 0,1,0,0,1,1,0,1,0,0,1,1,0. Required: y_out pulses after bit 7 and after bit 13, i.e. two one-cycle pulses.
- REQ-026 Bench: apply 0,0,0,1,1,0,0,0,1,0,0,1,1,0,1,0,0,0,0,0. Required: a single pulse after bit 14, with y_out=0 elsewhere.
- REQ-027 Bench: apply 0,1,0,0,1,0,0,1,1,0, which exercises the S5 -> S3 fallback. Required: a single pulse after bit 10.
- REQ-028 Bench: apply 0,1,0,0,1, then reset=1 for 1 edge, then 1,0. Required: no pulse.
